// File: rtl/nibble_word_packer.sv
// nibble_word_packer
//   Collects 4-bit nibbles from the upstream latch-then-flop path into
//   NIBBLES-wide words, LSB-first. The incoming nibble can optionally be
//   bit-reversed first. Completed or flushed words are held in a DEPTH-entry
//   valid/ready FIFO. Upstream cannot be stalled, so a word that arrives
//   while the FIFO is full is dropped and a sticky overflow flag is raised.
//
//   state  | meaning
//   -------+-----------------------------------------------
//   S_IDLE | pack register empty, fill = 0
//   S_FILL | 0 < fill < NIBBLES nibbles held in pack register
//
// Ports
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en, i_a      : nibble valid / nibble data
//   i_flush        : emit current partial word, zero padded
//   o_valid, i_ready, o_data, o_partial : output FIFO head handshake
//   o_fill         : nibbles currently held in the pack register
//   o_overflow     : sticky, a completed word was dropped
module nibble_word_packer #(
  parameter  int NIBBLES   = 4,
  parameter  int UNREVERSE = 1,
  parameter  int DEPTH     = 2,
  localparam int W         = 4 * NIBBLES
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [3:0]   i_a,
  input  logic         i_flush,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_partial,
  output logic [2:0]   o_fill,
  output logic         o_overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t          r_state;
  logic [2:0]      r_fill;
  logic [W-1:0]    r_pack;

  logic [W-1:0]    r_mem  [DEPTH];
  logic            r_pmem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [2:0]      r_count;
  logic            r_overflow;

  logic [3:0]      w_nib;
  logic [4:0]      w_sh;
  logic [W-1:0]    w_pack_nib;
  logic            w_complete;
  logic            w_push;
  logic [W-1:0]    w_push_data;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_wr;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_nib = i_a;
    if (UNREVERSE != 0) w_nib = {i_a[0], i_a[1], i_a[2], i_a[3]};
  end

  assign w_sh        = {r_fill, 2'b00};
  assign w_pack_nib  = r_pack | ({{(W-4){1'b0}}, w_nib} << w_sh);
  assign w_complete  = i_en && (r_fill == 3'(NIBBLES - 1));
  // A flush with a nibble in the same cycle includes that nibble, so a
  // flush from IDLE still pushes when i_en is high.
  assign w_push      = w_complete || (i_flush && (i_en || (r_state == S_FILL)));
  assign w_push_data = i_en ? w_pack_nib : r_pack;

  assign w_empty = (r_count == 3'd0);
  assign w_full  = (r_count == 3'(DEPTH));
  assign w_pop   = !w_empty && i_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO succeeds.
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_fill  <= 3'd0;
      r_pack  <= '0;
    end else if (w_push) begin
      // Pack register clears even when the word is dropped on overflow.
      r_state <= S_IDLE;
      r_fill  <= 3'd0;
      r_pack  <= '0;
    end else if (i_en) begin
      r_state <= S_FILL;
      r_fill  <= r_fill + 3'd1;
      r_pack  <= w_pack_nib;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i]  <= '0;
        r_pmem[i] <= 1'b0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= 3'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr]  <= w_push_data;
        r_pmem[r_wr_ptr] <= !w_complete;
        r_wr_ptr         <= f_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_push && !w_wr) r_overflow <= 1'b1;
    end
  end

  assign o_valid    = !w_empty;
  assign o_data     = w_empty ? '0   : r_mem[r_rd_ptr];
  assign o_partial  = w_empty ? 1'b0 : r_pmem[r_rd_ptr];
  assign o_fill     = r_fill;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_nibble_word_packer.sv
module tb_nibble_word_packer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_en = 1'b0;
  logic [3:0]  i_a = 4'd0;
  logic        i_flush = 1'b0;
  logic        i_ready = 1'b0;

  logic        r_valid, f_valid;
  logic [15:0] r_data, f_data;
  logic        r_part, f_part;
  logic [2:0]  r_fill, f_fill;
  logic        r_ovf, f_ovf;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: raw nibbles of the word being collected, and the
  // output FIFO as queues of finished words for both nibble mappings.
  logic [3:0]  cur [4];
  int          cur_cnt = 0;
  logic [15:0] q_rev [$];
  logic [15:0] q_fwd [$];
  bit          q_par [$];
  bit          m_ovf = 0;

  always #5 clk = ~clk;

  nibble_word_packer #(.NIBBLES(4), .UNREVERSE(1), .DEPTH(DEPTH)) u_rev (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_a(i_a), .i_flush(i_flush),
    .o_valid(r_valid), .i_ready(i_ready), .o_data(r_data), .o_partial(r_part),
    .o_fill(r_fill), .o_overflow(r_ovf));

  nibble_word_packer #(.NIBBLES(4), .UNREVERSE(0), .DEPTH(DEPTH)) u_fwd (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_a(i_a), .i_flush(i_flush),
    .o_valid(f_valid), .i_ready(i_ready), .o_data(f_data), .o_partial(f_part),
    .o_fill(f_fill), .o_overflow(f_ovf));

  function automatic logic [3:0] reverse4(input logic [3:0] a);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) r[3-b] = a[b];
    return r;
  endfunction

  function automatic logic [15:0] build(input bit rev);
    logic [15:0] w = 16'h0;
    for (int k = 0; k < cur_cnt; k++)
      w = w + (16'(rev ? reverse4(cur[k]) : cur[k]) * (16'd1 << (4 * k)));
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit          v = (q_fwd.size() != 0);
    logic [15:0] er = v ? q_rev[0] : 16'h0;
    logic [15:0] ef = v ? q_fwd[0] : 16'h0;
    bit          ep = v ? q_par[0] : 1'b0;
    chk({tag, ".rev.valid"},   32'(r_valid), 32'(v));
    chk({tag, ".rev.data"},    32'(r_data),  32'(er));
    chk({tag, ".rev.partial"}, 32'(r_part),  32'(ep));
    chk({tag, ".rev.fill"},    32'(r_fill),  32'(cur_cnt));
    chk({tag, ".rev.ovf"},     32'(r_ovf),   32'(m_ovf));
    chk({tag, ".fwd.valid"},   32'(f_valid), 32'(v));
    chk({tag, ".fwd.data"},    32'(f_data),  32'(ef));
    chk({tag, ".fwd.partial"}, 32'(f_part),  32'(ep));
    chk({tag, ".fwd.fill"},    32'(f_fill),  32'(cur_cnt));
    chk({tag, ".fwd.ovf"},     32'(f_ovf),   32'(m_ovf));
  endtask

  task automatic step(input string tag, input bit en, input logic [3:0] a,
                      input bit fl, input bit rd);
    bit pop, full, complete, push;
    i_en = en; i_a = a; i_flush = fl; i_ready = rd;
    @(posedge clk);
    pop  = (q_fwd.size() != 0) && rd;
    full = (q_fwd.size() == DEPTH);
    if (en) begin
      cur[cur_cnt] = a;
      cur_cnt++;
    end
    complete = en && (cur_cnt == 4);
    push     = complete || (fl && cur_cnt > 0);
    if (pop) begin
      void'(q_rev.pop_front());
      void'(q_fwd.pop_front());
      void'(q_par.pop_front());
    end
    if (push) begin
      if (full && !pop) m_ovf = 1;
      else begin
        q_rev.push_back(build(1));
        q_fwd.push_back(build(0));
        q_par.push_back(!complete);
      end
      cur_cnt = 0;
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    i_rst_n = 1'b0;
    #1;
    cur_cnt = 0; m_ovf = 0;
    q_rev.delete(); q_fwd.delete(); q_par.delete();
    check_all(tag);
    i_en = 0; i_flush = 0; i_ready = 0;
    @(negedge clk); @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    do_reset("reset");

    // Word assembly with bit reversal, one-cycle valid
    step("t1.n1", 1, 4'h1, 0, 1);
    step("t1.n2", 1, 4'h2, 0, 1);
    step("t1.n3", 1, 4'h3, 0, 1);
    step("t1.n4", 1, 4'h4, 0, 1);
    chk("t1.const_rev", 32'(r_data), 32'h2C48);
    chk("t1.const_fwd", 32'(f_data), 32'h4321);
    chk("t1.const_fill", 32'(r_fill), 32'd0);
    step("t1.pop", 0, 4'h0, 0, 1);
    chk("t1.one_cycle", 32'(r_valid), 32'd0);

    // Flush of a 3-nibble partial word, then a no-op flush in IDLE
    step("t2.n1", 1, 4'hA, 0, 1);
    step("t2.n2", 1, 4'hB, 0, 1);
    step("t2.n3", 1, 4'hC, 0, 1);
    step("t2.flush", 0, 4'h0, 1, 1);
    chk("t2.const_data", 32'(f_data), 32'h0CBA);
    chk("t2.const_part", 32'(f_part), 32'd1);
    step("t2.pop", 0, 4'h0, 0, 1);
    step("t2.idle_flush", 0, 4'h0, 1, 1);
    chk("t2.no_push", 32'(f_valid), 32'd0);

    // Flush together with a nibble
    step("t5.n1", 1, 4'h5, 0, 1);
    step("t5.n2f", 1, 4'h6, 1, 1);
    chk("t5.const_part_data", 32'(f_data), 32'h0065);
    chk("t5.const_part_flag", 32'(f_part), 32'd1);
    step("t5.n3", 1, 4'h7, 0, 1);
    step("t5.n4", 1, 4'h8, 0, 1);
    step("t5.n5", 1, 4'h9, 0, 1);
    step("t5.n6f", 1, 4'hA, 1, 1);
    chk("t5.const_full_data", 32'(f_data), 32'hA987);
    chk("t5.const_full_flag", 32'(f_part), 32'd0);
    step("t5.pop", 0, 4'h0, 0, 1);

    // Full FIFO with push and pop on the same edge
    for (int i = 0; i < 8; i++) step("t4.fill", 1, 4'(i), 0, 0);
    for (int i = 0; i < 3; i++) step("t4.part", 1, 4'(i + 8), 0, 0);
    step("t4.pushpop", 1, 4'hB, 0, 1);
    chk("t4.const_ovf", 32'(f_ovf), 32'd0);
    step("t4.drain1", 0, 4'h0, 0, 1);
    chk("t4.const_still_valid", 32'(f_valid), 32'd1);
    step("t4.drain2", 0, 4'h0, 0, 1);
    step("t4.empty", 0, 4'h0, 0, 1);

    // Overflow: three words into a 2-deep FIFO with no downstream ready
    for (int i = 0; i < 12; i++) step("t3.feed", 1, 4'($urandom), 0, 0);
    chk("t3.const_ovf", 32'(r_ovf), 32'd1);
    step("t3.pop1", 0, 4'h0, 0, 1);
    step("t3.pop2", 0, 4'h0, 0, 1);
    chk("t3.const_empty", 32'(f_valid), 32'd0);
    step("t3.idle", 0, 4'h0, 0, 1);

    // Asynchronous reset mid-word with a word in the FIFO
    do_reset("t6.clear_ovf");
    for (int i = 0; i < 6; i++) step("t6.feed", 1, 4'($urandom), 0, 0);
    #3;
    do_reset("t6.async");
    chk("t6.const_valid", 32'(r_valid), 32'd0);
    for (int i = 0; i < 4; i++) step("t6.clean", 1, 4'(i + 3), 0, 1);
    chk("t6.const_word", 32'(f_data), 32'h6543);

    // Randomized traffic
    for (int i = 0; i < 800; i++)
      step("rand", $urandom_range(0, 3) != 0, 4'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);

    do_reset("final_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_word_packer.md
Name: nibble_word_packer

Overview:
- Downstream consumer of the latch-then-flop nibble path. Collects the 4-bit o_a nibbles that path produces into NIBBLES-wide words.
- Optionally undoes the bit reversal applied upstream.
- Presents completed words to the next stage through a DEPTH-entry valid/ready output FIFO.
- Upstream has no backpressure, so this block detects and flags word loss.

Parameters:
- NIBBLES, 4, nibbles per output word; legal 2..8; word width W = 4*NIBBLES.
- UNREVERSE, 1, 1 = bit-reverse each incoming nibble before packing (i_a[0]→bit3 … i_a[3]→bit0); 0 = pack as received.
- DEPTH, 2, output FIFO entries; legal 1..4.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  nibble valid; i_a is sampled when high.
- i_a  in  4  nibble data (the upstream o_a).
- i_flush  in  1  emit the current partial word, zero-padded.
- o_valid  out  1  output word available (FIFO not empty).
- i_ready  in  1  downstream accepts the word when o_valid && i_ready.
- o_data  out  W  head-of-FIFO word.
- o_partial  out  1  head word was produced by a flush; qualified by o_valid.
- o_fill  out  3  nibbles currently held in the packing register, 0..NIBBLES-1.
- o_overflow  out  1  sticky: a completed word was dropped.

Behaviour:

Reset (async assert, sync-released use):
- All of the following are 0: o_valid, o_data, o_partial, o_fill, o_overflow, FIFO pointers, pack register.
- The FSM is in IDLE.
- Asserting reset mid-word discards the partial word and all FIFO contents.

Nibble mapping:
- n = UNREVERSE ? {i_a[0],i_a[1],i_a[2],i_a[3]} : i_a.
- Nibble k of a word (k = 0 first accepted) lands in bits [4k+3:4k], i.e. LSB-first.

FSM:
- States are IDLE (fill=0) and FILL (0<fill<NIBBLES).
- IDLE, i_en → FILL, fill=1. If NIBBLES would be reached, the word completes instead (not possible for NIBBLES≥2).
- FILL, i_en, fill<NIBBLES-1 → fill+1.
- FILL, i_en, fill==NIBBLES-1 → word complete; push to FIFO on the same edge; → IDLE, fill=0, pack register cleared.
- FILL, i_flush (no completion this cycle) → push pack register with unfilled nibbles zero, partial=1; → IDLE.
- i_flush with i_en in the same cycle: the nibble is included first.
  - If that nibble completes the word: push a full word with partial=0.
  - Otherwise: push a partial word containing that nibble.
- i_flush in IDLE without i_en: no-op, no push.

Latency:
- The last nibble is sampled at edge k → word is in the FIFO and o_valid=1 after edge k, provided the FIFO was empty.

FIFO:
- Pop on o_valid && i_ready.
- o_data and o_partial stay stable while o_valid && !i_ready.
- Push and pop in the same cycle when full: both succeed, occupancy unchanged, no overflow.
- Push when full without pop: the word is dropped and o_overflow is set.
  - The FIFO is unchanged; the pack register still clears and fill returns to 0.
  - o_overflow clears only on reset.
- Pop when empty: ignored.
- Pointers wrap modulo DEPTH.

o_fill:
- Registered copy of the fill count.
- Updates on the same edge as the nibble acceptance.

Test Plan:
1. NIBBLES=4, UNREVERSE=1, i_ready=1; i_a=1,2,3,4 with i_en on 4 consecutive cycles.
   → o_valid=1 for one cycle after the 4th edge; o_data=16'h2C48; o_partial=0; o_fill sequence 1,2,3,0.
2. UNREVERSE=0; 3 nibbles A,B,C, then i_flush alone.
   → o_data=16'h0CBA, o_partial=1, o_fill returns to 0. A later i_flush in IDLE produces no push.
3. DEPTH=2, i_ready=0; feed 12 nibbles (3 words).
   → words 1 and 2 are held with o_data stable; word 3 dropped; o_overflow=1.
   → Raise i_ready: exactly 2 pops in order, then o_valid=0.
4. FIFO full, i_ready=1 on the same cycle the 4th nibble completes a word.
   → pop and push both occur, o_overflow stays 0, occupancy stays 2.
5. Flush together with i_en on the 2nd nibble (UNREVERSE=0, nibbles 5,6).
   → o_data=16'h0065, partial=1.
   → Flush with the 4th nibble (7,8,9,A) → o_data=16'hA987, partial=0.
6. Assert i_rst_n=0 asynchronously mid-word (fill=2, FIFO holding 1 word).
   → o_valid, o_fill and o_overflow go 0 immediately without a clock edge.
   → After release, the next 4 nibbles form a clean word.
